// File: rtl/scene_mem_pkg.sv
// Shared definitions for the voxel scene memory paths (loader and readback).
package scene_mem_pkg;

    localparam int ADDR_BITS_DEF = 15;
    localparam int PACK_W_DEF    = 8;

    typedef enum logic [1:0] {
        RB_IDLE,
        RB_FETCH,
        RB_WAIT,
        RB_SEND
    } rb_state_t;

    function automatic int num_words(input int addr_bits, input int pack_w);
        return (2 ** addr_bits) / pack_w;
    endfunction

endpackage

// File: rtl/rb_bit_packer.sv
// Captures the one-bit memory read data into a PACK_W-wide word, qualified by
// the read enable and bit index delayed by one cycle to match the read latency.
module rb_bit_packer #(
    parameter int PACK_W = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  bit_idx,
    input  logic              rdata,
    output logic [PACK_W-1:0] pack
);

    logic              cap_en_reg;
    logic [IDX_W-1:0]  cap_idx_reg;
    logic [PACK_W-1:0] pack_reg;
    logic [PACK_W-1:0] wr_sel;

    genvar gi;
    generate
        for (gi = 0; gi < PACK_W; gi++) begin : g_sel
            assign wr_sel[gi] = cap_en_reg && (cap_idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_en_reg  <= 1'b0;
            cap_idx_reg <= '0;
            pack_reg    <= '0;
        end else begin
            cap_en_reg  <= rd_en;
            cap_idx_reg <= bit_idx;
            pack_reg    <= (pack_reg & ~wr_sel) | ({PACK_W{rdata}} & wr_sel);
        end
    end

    assign pack = pack_reg;

endmodule

// File: rtl/scene_readback_if.sv
// Streams the whole voxel occupancy memory to the host, PACK_W bits per word,
// LSB-first, with last-word framing and a done pulse.
module scene_readback_if
    import scene_mem_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int PACK_W    = PACK_W_DEF,
    localparam int IDX_BITS = $clog2(PACK_W),
    localparam int WC_W     = ADDR_BITS - IDX_BITS + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 load_mode,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] raddr,
    input  logic                 rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PACK_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [WC_W-1:0]      word_count
);

    localparam int IDX_W     = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int NUM_WORDS = num_words(ADDR_BITS, PACK_W);
    localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PACK_W - 1);

    rb_state_t             state_reg;
    logic [ADDR_BITS-1:0]  rd_addr_reg;
    logic [IDX_W-1:0]      bit_idx_reg;
    logic [WC_W-1:0]       word_count_reg;
    logic                  rd_en_reg;
    logic                  out_valid_reg;
    logic                  busy_reg;
    logic                  done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RB_IDLE;
            rd_addr_reg    <= '0;
            bit_idx_reg    <= '0;
            word_count_reg <= '0;
            rd_en_reg      <= 1'b0;
            out_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // Cancel path: word_count is deliberately left at its last value.
            if (state_reg != RB_IDLE && (abort || load_mode)) begin
                state_reg     <= RB_IDLE;
                rd_en_reg     <= 1'b0;
                out_valid_reg <= 1'b0;
                busy_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    RB_IDLE: begin
                        if (start && !load_mode && !abort) begin
                            state_reg      <= RB_FETCH;
                            rd_addr_reg    <= '0;
                            bit_idx_reg    <= '0;
                            word_count_reg <= '0;
                            rd_en_reg      <= 1'b1;
                            busy_reg       <= 1'b1;
                        end
                    end
                    RB_FETCH: begin
                        rd_addr_reg <= rd_addr_reg + ADDR_BITS'(1);
                        bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        if (bit_idx_reg == LAST_IDX) begin
                            state_reg   <= RB_WAIT;
                            rd_en_reg   <= 1'b0;
                            bit_idx_reg <= '0;
                        end
                    end
                    RB_WAIT: begin
                        state_reg     <= RB_SEND;
                        out_valid_reg <= 1'b1;
                    end
                    RB_SEND: begin
                        if (out_ready) begin
                            word_count_reg <= word_count_reg + WC_W'(1);
                            out_valid_reg  <= 1'b0;
                            if (word_count_reg == LAST_WORD) begin
                                state_reg <= RB_IDLE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg   <= RB_FETCH;
                                bit_idx_reg <= '0;
                                rd_en_reg   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg     <= RB_IDLE;
                        rd_en_reg     <= 1'b0;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                endcase
            end
        end
    end

    rb_bit_packer #(
        .PACK_W (PACK_W),
        .IDX_W  (IDX_W)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en_reg),
        .bit_idx (bit_idx_reg),
        .rdata   (rdata),
        .pack    (out_data)
    );

    assign rd_en      = rd_en_reg;
    assign raddr      = rd_addr_reg;
    assign out_valid  = out_valid_reg;
    assign out_last   = out_valid_reg && (word_count_reg == LAST_WORD);
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_scene_readback_if.sv
// Directed bench for scene_readback_if: 64 voxels, 8-bit words, 1-cycle memory model.
module tb_scene_readback_if;

    localparam int ADDR_BITS = 6;
    localparam int PACK_W    = 8;
    localparam int NVOX      = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 load_mode = 1'b0;
    logic                 rd_en;
    logic [ADDR_BITS-1:0] raddr;
    logic                 rdata = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [PACK_W-1:0]    out_data;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic [3:0]           word_count;

    logic mem [NVOX];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int done_cnt, rd_in_send, stab_err, first_valid_cyc, start_cyc;
    int busy_seen, rden_seen;
    bit held_valid, held_last;
    logic [PACK_W-1:0] held_data;
    logic [PACK_W-1:0] q_data[$];
    bit q_last[$];

    scene_readback_if #(
        .ADDR_BITS (ADDR_BITS),
        .PACK_W    (PACK_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .load_mode  (load_mode),
        .rd_en      (rd_en),
        .raddr      (raddr),
        .rdata      (rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (rd_en) rdata <= mem[raddr];
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_seen++;
        if (rd_en) rden_seen++;
        if (rd_en && out_valid) rd_in_send++;
        if (out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (held_valid && (out_data != held_data || out_last != held_last)) stab_err++;
            if (out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held_data  = out_data;
                held_last  = out_last;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic clear_stats();
        done_cnt = 0; rd_in_send = 0; stab_err = 0; first_valid_cyc = -1;
        busy_seen = 0; rden_seen = 0; held_valid = 1'b0;
        q_data.delete();
        q_last.delete();
    endtask

    task automatic start_pulse();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit rand_ready);
        int n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check({tag, "_timeout"}, (n >= 2000), 0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic mem_clear();
        for (int a = 0; a < NVOX; a++) mem[a] = 1'b0;
    endtask

    // Word i carries the value i, so misordered or restarted reads are visible.
    task automatic mem_index_pattern();
        for (int a = 0; a < NVOX; a++) mem[a] = 1'((a / 8) >> (a % 8));
    endtask

    task automatic check_words_index(input string tag);
        check({tag, "_nwords"}, q_data.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < q_data.size()) check($sformatf("%s_w%0d", tag, i), q_data[i], i);
        check({tag, "_wc"}, word_count, 8);
        check({tag, "_done"}, done_cnt, 1);
    endtask

    initial begin
        int n;
        mem_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rden", rd_en, 0);
        check("rst_done", done, 0);
        check("rst_wc", word_count, 0);
        check("rst_data", out_data, 0);
        check("rst_raddr", raddr, 0);

        // voxel(a) = a[0], ready always high
        for (int a = 0; a < NVOX; a++) mem[a] = 1'(a & 1);
        out_ready = 1'b1;
        clear_stats();
        start_pulse();
        wait_done("t1", 1'b0);
        check("t1_nwords", q_data.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < q_data.size()) begin
                check($sformatf("t1_w%0d", i), q_data[i], 32'hAA);
                check($sformatf("t1_last%0d", i), q_last[i], (i == 7) ? 1 : 0);
            end
        check("t1_latency", first_valid_cyc - start_cyc, 9);
        check("t1_done", done_cnt, 1);
        check("t1_wc", word_count, 8);
        check("t1_busy_after", busy, 0);

        // sparse voxels 5 and 63
        mem_clear();
        mem[5] = 1'b1;
        mem[63] = 1'b1;
        clear_stats();
        start_pulse();
        wait_done("t2", 1'b0);
        check("t2_nwords", q_data.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < q_data.size())
                check($sformatf("t2_w%0d", i), q_data[i], (i == 0) ? 32'h20 : (i == 7) ? 32'h80 : 32'h0);

        // random backpressure
        mem_index_pattern();
        clear_stats();
        start_pulse();
        wait_done("t3", 1'b1);
        check_words_index("t3");
        check("t3_stable", stab_err, 0);
        check("t3_rd_in_send", rd_in_send, 0);

        // abort during the third word's fetch
        clear_stats();
        start_pulse();
        n = 0;
        while (!(rd_en && word_count == 2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t4_reach", (n < 500), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_rden", rd_en, 0);
        check("t4_valid", out_valid, 0);
        check("t4_wc_hold", word_count, 2);
        repeat (5) @(posedge clk);
        #1;
        check("t4_no_done", done_cnt, 0);
        clear_stats();
        start_pulse();
        wait_done("t4b", 1'b0);
        check_words_index("t4b");

        // start ignored while the loader owns the memory
        clear_stats();
        load_mode = 1'b1;
        start_pulse();
        repeat (20) @(posedge clk);
        #1;
        check("t5_busy_seen", busy_seen, 0);
        check("t5_rden_seen", rden_seen, 0);
        load_mode = 1'b0;

        // load_mode raised while a word is waiting in SEND
        out_ready = 1'b0;
        clear_stats();
        start_pulse();
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_valid_seen", out_valid, 1);
        load_mode = 1'b1;
        @(posedge clk); #1;
        check("t5_lm_valid", out_valid, 0);
        check("t5_lm_busy", busy, 0);
        load_mode = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_lm_no_done", done_cnt, 0);

        // asynchronous reset in the middle of word 5
        clear_stats();
        start_pulse();
        n = 0;
        while (!(rd_en && word_count == 4) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach", (n < 500), 1);
        rst_n = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_rden", rd_en, 0);
        check("t6_wc", word_count, 0);
        check("t6_raddr", raddr, 0);
        check("t6_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_stats();
        start_pulse();
        wait_done("t6b", 1'b0);
        check_words_index("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
